// File: rtl/router_output_arbiter.sv
// Round-robin arbiter granting one router output port to one of N_PORTS inputs,
// holding the grant for a whole frame and enforcing a one-cycle inter-frame gap.
module router_output_arbiter #(
  parameter int N_PORTS  = 16,
  parameter int ID_W     = 4,
  parameter int HOLD_MAX = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] done,
  output logic [N_PORTS-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_PORTS - 1);
  localparam logic [ID_W:0]    NP       = (ID_W + 1)'(N_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    GAP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [N_PORTS-1:0] win_onehot;
  logic [ID_W:0]      scan_sum;
  logic [ID_W-1:0]    scan_idx;
  logic               owner_fin;
  logic               owner_abort;
  logic               expire;
  logic               leave_owned;
  logic               timed_out;

  // Round-robin search: first requester strictly after ptr, wrapping back to ptr itself last.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      scan_sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (scan_sum >= NP) begin
        scan_sum = scan_sum - NP;
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
    win_onehot[win_id] = win_found;
  end

  always_comb begin
    state_d     = state_q;
    owner_fin   = done[grant_id];
    owner_abort = !req[grant_id];
    expire      = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM);
    leave_owned = 1'b0;
    timed_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (owner_fin || owner_abort || expire) begin
          state_d     = GAP;
          leave_owned = 1'b1;
          // Completion or abort in the expiry cycle is a normal exit, not a timeout.
          timed_out   = expire && !owner_fin && !owner_abort;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= PTR_INIT;
    end else begin
      timeout_err <= timed_out;
      if (state_q == IDLE && win_found) begin
        grant    <= win_onehot;
        grant_id <= win_id;
        busy     <= 1'b1;
        hold_cnt <= HOLD_ONE;
      end else if (leave_owned) begin
        grant    <= '0;
        grant_id <= '0;
        busy     <= 1'b0;
        ptr      <= grant_id;
        hold_cnt <= '0;
      end else if (state_q == OWNED) begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end
    end
  end

endmodule
